// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl_pkg
// Purpose  : Shared RV32I opcode defines and hazard-sequencer constants.
// Revision : 1.0 - initial release
// ============================================================================
package hazard_ctrl_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam int         PEND_W_DEF = 2;
    localparam int         NREG_DEF   = 32;
    localparam logic [4:0] ZERO_REG   = 5'd0;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_FLUSH1 = 1'b1
    } flush_state_e;

endpackage
`default_nettype wire

// File: rtl/hz_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hz_scoreboard
// Purpose  : Per-register pending-write counters with RAW/saturation lookup.
//            Optional write-through bypass: HAZARD_WB_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module hz_scoreboard
    import hazard_ctrl_pkg::*;
#(
    parameter int PEND_W = PEND_W_DEF,
    parameter int NREG   = NREG_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] rs1_addr,
    input  logic [4:0] rs2_addr,
    input  logic [4:0] wd_addr,
    input  logic       inc_en,
    input  logic       dec_en,
    input  logic [4:0] dec_addr,
    output logic       pend_nz_rs1,
    output logic       pend_nz_rs2,
    output logic       pend_full_wd,
    output logic       sb_err
);

    localparam logic [PEND_W-1:0] c_one = PEND_W'(1);

    logic [PEND_W-1:0] w_pend [NREG];
    logic              r_err;
    logic              w_byp_rs1;
    logic              w_byp_rs2;
    logic              w_dec_nz;

    generate
        for (genvar i = 0; i < NREG; i++) begin : g_reg
            if (i == 0) begin : g_zero
                assign w_pend[i] = '0;
            end else begin : g_cnt
                logic [PEND_W-1:0] r_cnt;
                logic              w_inc;
                logic              w_dec;

                assign w_inc = inc_en && (wd_addr == 5'(i));
                assign w_dec = dec_en && (dec_addr == 5'(i));

                // Simultaneous issue and writeback cancel; underflow holds at 0.
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        r_cnt <= '0;
                    end else if (w_inc && !w_dec) begin
                        r_cnt <= r_cnt + c_one;
                    end else if (w_dec && !w_inc && (r_cnt != '0)) begin
                        r_cnt <= r_cnt - c_one;
                    end
                end

                assign w_pend[i] = r_cnt;
            end
        end
    endgenerate

`ifdef HAZARD_WB_BYPASS_EN
    // Last outstanding write landing this cycle is written through the regfile.
    assign w_byp_rs1 = dec_en && (dec_addr == rs1_addr) && (w_pend[rs1_addr] == c_one);
    assign w_byp_rs2 = dec_en && (dec_addr == rs2_addr) && (w_pend[rs2_addr] == c_one);
`else
    assign w_byp_rs1 = 1'b0;
    assign w_byp_rs2 = 1'b0;
`endif

    assign pend_nz_rs1  = (w_pend[rs1_addr] != '0) && !w_byp_rs1;
    assign pend_nz_rs2  = (w_pend[rs2_addr] != '0) && !w_byp_rs2;
    assign pend_full_wd = (wd_addr != ZERO_REG) && (w_pend[wd_addr] == '1);

    assign w_dec_nz = dec_en && (dec_addr != ZERO_REG);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_dec_nz && (w_pend[dec_addr] == '0)) begin
            r_err <= 1'b1;
        end
    end

    assign sb_err = r_err;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : RV32I stall/flush sequencer: scoreboard RAW stalls, jump flush.
//            Optional write-through bypass: HAZARD_WB_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int PEND_W = PEND_W_DEF,
    parameter int NREG   = NREG_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid_i,
    input  logic [4:0]  rs1_addr_i,
    input  logic [4:0]  rs2_addr_i,
    input  logic [4:0]  wd_addr_i,
    input  logic        reg_wen_i,
    input  logic        wb_wen_i,
    input  logic [4:0]  wb_addr_i,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    output logic        stall_o,
    output logic        flush_o,
    output logic        issue_o,
    output logic        jump_en_o,
    output logic [31:0] jump_addr_o,
    output logic        sb_err_o
);

    flush_state_e r_state;

    logic w_nz_rs1;
    logic w_nz_rs2;
    logic w_full_wd;
    logic w_raw;
    logic w_sat;
    logic w_flush;
    logic w_stall;
    logic w_issue;
    logic w_inc_en;

    hz_scoreboard #(
        .PEND_W (PEND_W),
        .NREG   (NREG)
    ) u_sb (
        .clk          (clk),
        .rst_n        (rst_n),
        .rs1_addr     (rs1_addr_i),
        .rs2_addr     (rs2_addr_i),
        .wd_addr      (wd_addr_i),
        .inc_en       (w_inc_en),
        .dec_en       (wb_wen_i),
        .dec_addr     (wb_addr_i),
        .pend_nz_rs1  (w_nz_rs1),
        .pend_nz_rs2  (w_nz_rs2),
        .pend_full_wd (w_full_wd),
        .sb_err       (sb_err_o)
    );

    assign w_raw    = id_valid_i && (w_nz_rs1 || w_nz_rs2);
    assign w_sat    = id_valid_i && reg_wen_i && w_full_wd;

    // Flush wins over stall: the stalled instruction is on the wrong path anyway.
    assign w_flush  = rst_n && (jump_en_i || (r_state == ST_FLUSH1));
    assign w_stall  = rst_n && (w_raw || w_sat) && !w_flush;
    assign w_issue  = rst_n && id_valid_i && !w_stall && !w_flush;
    assign w_inc_en = w_issue && reg_wen_i && (wd_addr_i != ZERO_REG);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            case (r_state)
                ST_RUN:    if (jump_en_i)  r_state <= ST_FLUSH1;
                ST_FLUSH1: if (!jump_en_i) r_state <= ST_RUN;
                default:   r_state <= ST_RUN;
            endcase
        end
    end

    assign stall_o     = w_stall;
    assign flush_o     = w_flush;
    assign issue_o     = w_issue;
    assign jump_en_o   = rst_n && jump_en_i;
    assign jump_addr_o = rst_n ? jump_addr_i : 32'd0;

endmodule
`default_nettype wire
